// File: rtl/gpio_input_conditioner_if.sv
// Avalon-MM slave bus carrying the divider/threshold/status register accesses
// of the GPIO input conditioner.
interface gpio_input_conditioner_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-bit synchronizer, tick-based debouncer and
// registered rise/fall pulse generator, configured over an Avalon-MM slave.
module gpio_input_conditioner #(
  parameter int          DW          = 31,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DEFAULT_DIV = 16'd50000,
  parameter logic [3:0]  DEFAULT_THR = 4'd4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW:0]              raw_in,
  gpio_input_conditioner_if.slave  bus,
  output logic [DW:0]              clean_out,
  output logic [DW:0]              rise_pulse,
  output logic [DW:0]              fall_pulse
);

  typedef enum logic [1:0] {
    ADDR_DIV   = 2'd0,
    ADDR_THR   = 2'd1,
    ADDR_SYNC  = 2'd2,
    ADDR_CLEAN = 2'd3
  } reg_addr_e;

  logic [SYNC_STAGES-1:0][DW:0] sync_q;
  logic [DW:0]                  sync;

  logic [15:0]        div_q, div_d;
  logic [3:0]         thr_q, thr_d;
  logic [15:0]        pcnt_q, pcnt_d;
  logic [DW:0][3:0]   cnt_q, cnt_d;
  logic [DW:0]        clean_q, clean_d;
  logic [DW:0]        rise_q, rise_d;
  logic [DW:0]        fall_q, fall_d;
  logic [31:0]        readdata_q, readdata_d;
  logic [31:0]        rd_sel;

  logic wr_en;
  logic div_wr;
  logic thr_wr;
  logic tick;
  logic tick_eff;
  logic unused_bus;

  assign sync = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign wr_en    = bus.chipselect & bus.write;
  assign div_wr   = wr_en && (reg_addr_e'(bus.address) == ADDR_DIV);
  assign thr_wr   = wr_en && (reg_addr_e'(bus.address) == ADDR_THR);

  // DIV of 0 or 1 both mean "every cycle"; a config write swallows the tick.
  assign tick     = (div_q <= 16'd1) || (pcnt_q == div_q - 16'd1);
  assign tick_eff = tick & ~(div_wr | thr_wr);

  assign div_d  = div_wr ? bus.writedata[15:0] : div_q;
  assign thr_d  = thr_wr ? bus.writedata[3:0]  : thr_q;

  always_comb begin
    pcnt_d = pcnt_q + 16'd1;
    if (div_wr || tick) begin
      pcnt_d = '0;
    end
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    for (int i = 0; i <= DW; i++) begin
      if (thr_wr) begin
        cnt_d[i] = '0;
      end else if (thr_q == 4'd0) begin
        cnt_d[i]   = '0;
        clean_d[i] = sync[i];
      end else if (sync[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_eff) begin
        if (cnt_q[i] + 4'd1 == thr_q) begin
          cnt_d[i]   = '0;
          clean_d[i] = ~clean_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign rise_d = clean_d & ~clean_q;
  assign fall_d = ~clean_d & clean_q;

  always_comb begin
    rd_sel = '0;
    unique case (reg_addr_e'(bus.address))
      ADDR_DIV:   rd_sel[15:0] = div_q;
      ADDR_THR:   rd_sel[3:0]  = thr_q;
      ADDR_SYNC:  rd_sel[DW:0] = sync;
      ADDR_CLEAN: rd_sel[DW:0] = clean_q;
    endcase
  end

  assign readdata_d = bus.chipselect ? rd_sel : readdata_q;

  // NOTE: the per-bit counter array is ordinary flops, not a RAM, so it is
  // reset alongside the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= DEFAULT_DIV;
      thr_q      <= DEFAULT_THR;
      pcnt_q     <= '0;
      cnt_q      <= '0;
      clean_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      readdata_q <= '0;
    end else begin
      div_q      <= div_d;
      thr_q      <= thr_d;
      pcnt_q     <= pcnt_d;
      cnt_q      <= cnt_d;
      clean_q    <= clean_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      readdata_q <= readdata_d;
    end
  end

  assign clean_out    = clean_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign bus.readdata = readdata_q;

  // Reads act on chipselect alone; read strobe and high write bits are unused.
  assign unused_bus = ^{bus.read, bus.writedata[31:16]};

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed testbench for gpio_input_conditioner: reset, debounce latency,
// glitch rejection, prescaler phase, bypass mode and register file.
module tb_gpio_input_conditioner;

  localparam int DW = 31;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [DW:0]   raw_in = '0;
  logic [DW:0]   clean_out;
  logic [DW:0]   rise_pulse;
  logic [DW:0]   fall_pulse;

  int n_cmp = 0;
  int n_mis = 0;

  gpio_input_conditioner_if bus ();

  gpio_input_conditioner #(
    .DW          (DW),
    .SYNC_STAGES (2),
    .DEFAULT_DIV (16'd50000),
    .DEFAULT_THR (4'd4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .bus        (bus),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    cycle();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    cycle();
    d              = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    raw_in = '0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #1 reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (clean_out !== '0) begin n_mis++; $display("FAIL reset_clean: got %h want 0", clean_out); end
    n_cmp++; if (rise_pulse !== '0) begin n_mis++; $display("FAIL reset_rise: got %h want 0", rise_pulse); end
    n_cmp++; if (fall_pulse !== '0) begin n_mis++; $display("FAIL reset_fall: got %h want 0", fall_pulse); end
    n_cmp++; if (bus.readdata !== 32'h0) begin n_mis++; $display("FAIL reset_readdata: got %h want 0", bus.readdata); end
    reset = 1'b0;
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'd50000) begin n_mis++; $display("FAIL reset_div: got %0d want 50000", rd); end
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'd4) begin n_mis++; $display("FAIL reset_thr: got %0d want 4", rd); end
  endtask

  task automatic test_clean_step();
    logic [DW:0] exp_clean, exp_rise;
    apply_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'd1);
    repeat (3) cycle();
    raw_in[5] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      exp_clean = (j >= 4) ? 32'h0000_0020 : 32'h0;
      exp_rise  = (j == 4) ? 32'h0000_0020 : 32'h0;
      n_cmp++; if (clean_out !== exp_clean) begin n_mis++; $display("FAIL step_clean[k+%0d]: got %h want %h", j, clean_out, exp_clean); end
      n_cmp++; if (rise_pulse !== exp_rise) begin n_mis++; $display("FAIL step_rise[k+%0d]: got %h want %h", j, rise_pulse, exp_rise); end
      n_cmp++; if (fall_pulse !== '0) begin n_mis++; $display("FAIL step_fall[k+%0d]: got %h want 0", j, fall_pulse); end
    end
  endtask

  // Continues from test_clean_step with clean_out[5] already set.
  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'd3) begin n_mis++; $display("FAIL mid_thr_read: got %0d want 3", rd); end
    n_cmp++; if (clean_out !== 32'h0000_0020) begin n_mis++; $display("FAIL mid_pre_clean: got %h want 00000020", clean_out); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (clean_out !== '0) begin n_mis++; $display("FAIL mid_clean: got %h want 0", clean_out); end
    n_cmp++; if (rise_pulse !== '0 || fall_pulse !== '0) begin n_mis++; $display("FAIL mid_pulses: got %h/%h want 0/0", rise_pulse, fall_pulse); end
    n_cmp++; if (bus.readdata !== 32'h0) begin n_mis++; $display("FAIL mid_readdata: got %h want 0", bus.readdata); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) cycle();
    n_cmp++; if (clean_out !== '0 || fall_pulse !== '0) begin n_mis++; $display("FAIL mid_after: got %h/%h want 0/0", clean_out, fall_pulse); end
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'd4) begin n_mis++; $display("FAIL mid_thr_default: got %0d want 4", rd); end
  endtask

  task automatic test_glitch();
    logic [DW:0] seen_clean, seen_rise, seen_fall;
    logic [DW:0] exp_clean, exp_rise, exp_fall;
    apply_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'd1);
    repeat (3) cycle();
    // Two sampled cycles high: one short of the threshold.
    seen_clean = '0; seen_rise = '0; seen_fall = '0;
    raw_in[0] = 1'b1;
    cycle();
    cycle();
    raw_in[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cycle();
      seen_clean |= clean_out;
      seen_rise  |= rise_pulse;
      seen_fall  |= fall_pulse;
    end
    n_cmp++; if (seen_clean !== '0) begin n_mis++; $display("FAIL glitch_clean: got %h want 0", seen_clean); end
    n_cmp++; if (seen_rise !== '0) begin n_mis++; $display("FAIL glitch_rise: got %h want 0", seen_rise); end
    n_cmp++; if (seen_fall !== '0) begin n_mis++; $display("FAIL glitch_fall: got %h want 0", seen_fall); end
    // Three sampled cycles high: exactly the threshold, passes through.
    raw_in[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      cycle();
      exp_clean = (j >= 4 && j <= 6) ? 32'h1 : 32'h0;
      exp_rise  = (j == 4) ? 32'h1 : 32'h0;
      exp_fall  = (j == 7) ? 32'h1 : 32'h0;
      n_cmp++; if (clean_out !== exp_clean) begin n_mis++; $display("FAIL pass3_clean[k+%0d]: got %h want %h", j, clean_out, exp_clean); end
      n_cmp++; if (rise_pulse !== exp_rise) begin n_mis++; $display("FAIL pass3_rise[k+%0d]: got %h want %h", j, rise_pulse, exp_rise); end
      n_cmp++; if (fall_pulse !== exp_fall) begin n_mis++; $display("FAIL pass3_fall[k+%0d]: got %h want %h", j, fall_pulse, exp_fall); end
      if (j == 2) raw_in[0] = 1'b0;
    end
  endtask

  task automatic test_prescaler();
    int delta;
    int n_fall;
    logic seen_rise;
    apply_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'd10);
    raw_in[31] = 1'b1;
    repeat (40) cycle();
    n_cmp++; if (clean_out !== 32'h8000_0000) begin n_mis++; $display("FAIL presc_setup: got %h want 80000000", clean_out); end
    raw_in[31] = 1'b0;
    cycle();
    cycle();
    delta = -1; n_fall = 0; seen_rise = 1'b0;
    for (int d = 1; d <= 40; d++) begin
      cycle();
      if (fall_pulse[31]) begin
        n_fall++;
        if (delta < 0) delta = d;
      end
      if (rise_pulse != '0) seen_rise = 1'b1;
    end
    n_cmp++; if (delta < 11 || delta > 21) begin n_mis++; $display("FAIL presc_latency: got %0d cycles want 11..21", delta); end
    n_cmp++; if (n_fall != 1) begin n_mis++; $display("FAIL presc_fall_width: got %0d cycles want 1", n_fall); end
    n_cmp++; if (seen_rise !== 1'b0) begin n_mis++; $display("FAIL presc_no_rise: got %b want 0", seen_rise); end
    n_cmp++; if (clean_out !== '0) begin n_mis++; $display("FAIL presc_final: got %h want 0", clean_out); end
  endtask

  // A DIV rewrite mid-period must push the next tick a full period out.
  task automatic test_div_restart();
    logic [DW:0] exp_clean, exp_rise;
    apply_reset();
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd10);
    repeat (5) cycle();
    raw_in[3] = 1'b1;
    bus_write(2'd0, 32'd10);
    for (int j = 1; j <= 11; j++) begin
      cycle();
      exp_clean = (j >= 10) ? 32'h8 : 32'h0;
      exp_rise  = (j == 10) ? 32'h8 : 32'h0;
      n_cmp++; if (clean_out !== exp_clean) begin n_mis++; $display("FAIL restart_clean[w+%0d]: got %h want %h", j, clean_out, exp_clean); end
      n_cmp++; if (rise_pulse !== exp_rise) begin n_mis++; $display("FAIL restart_rise[w+%0d]: got %h want %h", j, rise_pulse, exp_rise); end
    end
  endtask

  task automatic test_bypass();
    logic [DW:0] exp_clean, exp_rise, exp_fall;
    apply_reset();
    bus_write(2'd1, 32'd0);
    raw_in[7] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cycle();
      if (j == 0) raw_in[7] = 1'b0;
      exp_clean = (j == 2) ? 32'h80 : 32'h0;
      exp_rise  = (j == 2) ? 32'h80 : 32'h0;
      exp_fall  = (j == 3) ? 32'h80 : 32'h0;
      n_cmp++; if (clean_out !== exp_clean) begin n_mis++; $display("FAIL bypass_clean[k+%0d]: got %h want %h", j, clean_out, exp_clean); end
      n_cmp++; if (rise_pulse !== exp_rise) begin n_mis++; $display("FAIL bypass_rise[k+%0d]: got %h want %h", j, rise_pulse, exp_rise); end
      n_cmp++; if (fall_pulse !== exp_fall) begin n_mis++; $display("FAIL bypass_fall[k+%0d]: got %h want %h", j, fall_pulse, exp_fall); end
    end
  endtask

  task automatic test_regfile();
    logic [31:0] rd;
    apply_reset();
    bus_write(2'd0, 32'hABCD_1234);
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h0000_1234) begin n_mis++; $display("FAIL reg_div: got %h want 00001234", rd); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'h0000_000F) begin n_mis++; $display("FAIL reg_thr: got %h want 0000000f", rd); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL reg_clean_ro: got %h want 0", rd); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h0000_1234) begin n_mis++; $display("FAIL reg_div_kept: got %h want 00001234", rd); end
    raw_in = 32'hA5A5_0F0F;
    repeat (3) cycle();
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'hA5A5_0F0F) begin n_mis++; $display("FAIL reg_sync: got %h want a5a50f0f", rd); end
    raw_in = 32'h0;
    repeat (3) cycle();
    n_cmp++; if (bus.readdata !== 32'hA5A5_0F0F) begin n_mis++; $display("FAIL reg_hold: got %h want a5a50f0f", bus.readdata); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd1);
    repeat (2) cycle();
    raw_in = 32'h3;
    repeat (3) cycle();
    n_cmp++; if (clean_out !== 32'h3 || rise_pulse !== 32'h3) begin n_mis++; $display("FAIL b2b_rise: got %h/%h want 3/3", clean_out, rise_pulse); end
    raw_in = 32'h5;
    repeat (3) cycle();
    n_cmp++; if (clean_out !== 32'h5 || rise_pulse !== 32'h4 || fall_pulse !== 32'h2) begin
      n_mis++; $display("FAIL b2b_mixed: got %h/%h/%h want 5/4/2", clean_out, rise_pulse, fall_pulse);
    end
    cycle();
    n_cmp++; if (rise_pulse !== '0 || fall_pulse !== '0) begin n_mis++; $display("FAIL b2b_clear: got %h/%h want 0/0", rise_pulse, fall_pulse); end
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = 32'h0;
    test_reset();
    test_clean_step();
    test_reset_mid();
    test_glitch();
    test_prescaler();
    test_div_restart();
    test_bypass();
    test_regfile();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Input-conditioning stage between the raw GPIO_0 expansion-header pins and the Avalon parallel-port block that captures them. It synchronizes each of the DW+1 input bits into `clk`, debounces them against a programmable sample tick and stable-count threshold, and emits per-bit one-cycle rise and fall pulses. Divider and threshold are set through a small Avalon-MM slave. `clean_out` replaces the raw pin vector at the parallel port's input register.

## Interface
- `DW`, 31: data width minus 1.
- `SYNC_STAGES`, 2: synchronizer depth, minimum 2.
- `DEFAULT_DIV`, 16'd50000: divider reset value (1 ms tick at 50 MHz).
- `DEFAULT_THR`, 4'd4: threshold reset value.

- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `raw_in`  in  DW+1: header pins, already remapped to contiguous bits.
- `address`  in  2: register select.
- `chipselect`, `read`, `write`  in  1 each: Avalon-MM strobes.
- `writedata`  in  32: write data.
- `readdata`  out  32: registered read data.
- `clean_out`  out  DW+1: debounced levels.
- `rise_pulse`  out  DW+1: per-bit one-cycle pulse on clean 0→1.
- `fall_pulse`  out  DW+1: per-bit one-cycle pulse on clean 1→0.

## Operation
- Registers:
  - Address 0, DIV, R/W, bits [15:0]: sample-tick period in clocks.
  - Address 1, THR, R/W, bits [3:0]: ticks of continuous disagreement needed to flip `clean_out`.
  - Address 2, SYNC, read-only: synchronized input vector.
  - Address 3, CLEAN, read-only: `clean_out`.
  - Unused bits read as 0. Writes to addresses 2 and 3 are ignored.
- Synchronizer: SYNC_STAGES flops per bit. `sync` is the last stage.
- Prescaler, 16-bit counter `pcnt`:
  - `tick` = (`pcnt` == DIV−1). On `tick`, `pcnt` wraps to 0.
  - DIV = 0 or 1: `tick` is asserted every cycle.
  - A write to DIV clears `pcnt` in the same cycle.
- Per-bit debounce, 4-bit counter `cnt[i]`:
  - `sync[i]` == `clean[i]`: `cnt[i]` is cleared every cycle, with or without `tick`.
  - Mismatch on a `tick` cycle, `cnt[i]`+1 == THR: `clean[i]` toggles and `cnt[i]` clears.
  - Mismatch on a `tick` cycle, otherwise: `cnt[i]` increments.
  - Mismatch without `tick`: `cnt[i]` holds.
- THR = 0: bypass mode. `clean` takes `sync` every cycle and all `cnt` stay 0.
- Writing THR clears all `cnt[i]`. `clean` is not changed by the write.
- Edge pulses are registered and update on the same edge as `clean`:
  - `rise_pulse` <= `next_clean` & ~`clean`.
  - `fall_pulse` <= ~`next_clean` & `clean`.
  - Each pulse is exactly 1 cycle wide. Pulses on different bits are independent and may coincide.
- Read: `readdata` loads the selected register on the edge where `chipselect` is high, and holds otherwise. `read` is not required, matching the parallel-port convention.
- A write and a tick in the same cycle: the write takes effect and the tick is lost.

## Timing
- Reset asserted (asynchronous, immediate), all cleared to the values below:
  - sync flops, `pcnt`, every `cnt`, `clean_out`, `rise_pulse`, `fall_pulse`, `readdata`: 0.
  - DIV: DEFAULT_DIV. THR: DEFAULT_THR.
- Reset released: the first tick occurs DIV cycles after the first clock edge with `reset` low.
- Reset mid-debounce discards partial counts; no pulse is generated by reset.
- Latency, raw change sampled at edge k:
  - `sync` changes at edge k+SYNC_STAGES−1.
  - With DIV=1, `clean` and the pulse change at edge k+SYNC_STAGES−1+THR.
  - Bypass mode: edge k+SYNC_STAGES.
- General DIV: flip occurs between THR−1 and THR tick periods after `sync` changes, plus up to DIV−1 cycles of phase.
- Glitch rejection: a `sync` deviation shorter than THR consecutive ticks never reaches `clean`, because the count restarts on agreement.
- Register read latency: 1 cycle.
- Register write effect: DIV/THR visible in readback and in use from the next cycle.

## Test plan
- Reset values: assert `reset` mid-run → all outputs 0 immediately; read DIV=50000 and THR=4.
- Clean step, DIV=1, THR=3: raw bit 5 rises at edge 10 → `clean_out[5]`=1 and `rise_pulse[5]` high for exactly 1 cycle at edge 14; no other bits change.
- Glitch rejection, DIV=1, THR=3: raw bit 0 high for 2 cycles → `clean_out[0]` stays 0 and no pulses.
- Prescaler, DIV=10, THR=2: a falling step on bit 31 → `fall_pulse[31]` asserts between 11 and 21 cycles after `sync` changes; write DIV mid-count → `pcnt` restarts at 0.
- Bypass, THR=0: a 1-cycle raw pulse on bit 7 → `clean_out[7]` high for 1 cycle at edge k+2, with `rise_pulse` and `fall_pulse` each asserted once.
- Register file: write DIV=0x1234, THR=0xF → readback 0x00001234 and 0x0000000F; write address 3 is ignored; read address 2 returns the `sync` vector.
